// File: rtl/wb_master_engine_if.sv
// Wishbone B4 classic bus bundle between the master engine and a slave.
// Signal names keep the Wishbone _O/_I suffixes as seen from the master.
interface wb_master_engine_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADR_W  = 64
);
  logic                  CYC_O;
  logic                  STB_O;
  logic                  WE_O;
  logic                  LOCK_O;
  logic [ADR_W-1:0]      ADR_O;
  logic [DATA_W-1:0]     DAT_O;
  logic [DATA_W/8-1:0]   SEL_O;
  logic [DATA_W-1:0]     DAT_I;
  logic                  ACK_I;
  logic                  ERR_I;
  logic                  RTY_I;

  modport master (
    output CYC_O, STB_O, WE_O, LOCK_O, ADR_O, DAT_O, SEL_O,
    input  DAT_I, ACK_I, ERR_I, RTY_I
  );

  modport slave (
    input  CYC_O, STB_O, WE_O, LOCK_O, ADR_O, DAT_O, SEL_O,
    output DAT_I, ACK_I, ERR_I, RTY_I
  );
endinterface

// File: rtl/wb_master_engine.sv
// Wishbone B4 classic master: command FIFO feeding a transfer FSM with RTY retry/backoff.
// Optional wait-state timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_engine #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADR_W       = 64,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned BACKOFF     = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADR_W-1:0]      cmd_adr,
  input  logic [DATA_W-1:0]     cmd_dat,
  input  logic [DATA_W/8-1:0]   cmd_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_dat,
  output logic [1:0]            rsp_status,
  wb_master_engine_if.master    wb
);
  localparam int unsigned SelW = DATA_W / 8;
  localparam int unsigned PtrW = $clog2(CMD_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned RtyW = $clog2(MAX_RETRY + 2);
  localparam int unsigned BoW  = $clog2(BACKOFF + 2);

  localparam logic [1:0] StsOk  = 2'b00;
  localparam logic [1:0] StsErr = 2'b01;
  localparam logic [1:0] StsRty = 2'b10;
  localparam logic [1:0] StsTmo = 2'b11;

  typedef enum logic [1:0] {StIdle, StCycle, StBackoff, StResp} state_e;

  state_e state_q, state_d;

  logic [ADR_W-1:0]  fifo_adr [CMD_DEPTH];
  logic [DATA_W-1:0] fifo_dat [CMD_DEPTH];
  logic [SelW-1:0]   fifo_sel [CMD_DEPTH];
  logic              fifo_we  [CMD_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              full, empty, push, pop, issue, tmo;

  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d, rsp_dat_q, rsp_dat_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [1:0]        status_q, status_d;
  logic [RtyW-1:0]   retry_q, retry_d;
  logic [BoW-1:0]    bo_q, bo_d;

  // Readiness depends on occupancy only, so a full FIFO refuses even with a same-cycle pop.
  assign full      = (cnt_q == CntW'(CMD_DEPTH));
  assign empty     = (cnt_q == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adr[wr_ptr_q] <= cmd_adr;
      fifo_dat[wr_ptr_q] <= cmd_dat;
      fifo_sel[wr_ptr_q] <= cmd_sel;
      fifo_we[wr_ptr_q]  <= cmd_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    status_d  = status_q;
    retry_d   = retry_q;
    bo_d      = bo_q;
    pop       = 1'b0;
    issue     = 1'b0;
    case (state_q)
      StIdle: issue = ~empty;
      StCycle: begin
        if (wb.ERR_I || wb.RTY_I || wb.ACK_I || tmo) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
        end
        if (wb.ERR_I) begin
          status_d  = StsErr;
          rsp_dat_d = '0;
          state_d   = StResp;
        end else if (wb.RTY_I) begin
          if (retry_q < RtyW'(MAX_RETRY)) begin
            retry_d = retry_q + RtyW'(1);
            bo_d    = '0;
            state_d = StBackoff;
          end else begin
            status_d  = StsRty;
            rsp_dat_d = '0;
            state_d   = StResp;
          end
        end else if (wb.ACK_I) begin
          status_d  = StsOk;
          rsp_dat_d = we_q ? '0 : wb.DAT_I;
          state_d   = StResp;
        end else if (tmo) begin
          status_d  = StsTmo;
          rsp_dat_d = '0;
          state_d   = StResp;
        end
      end
      StBackoff: begin
        if (int'(bo_q) + 1 >= int'(BACKOFF)) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = StCycle;
        end else begin
          bo_d = bo_q + BoW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          retry_d = '0;
          state_d = StIdle;
          issue   = ~empty;  // skip IDLE so back-to-back cycles are separated by RESP only
        end
      end
      default: state_d = StIdle;
    endcase
    if (issue) begin
      pop     = 1'b1;
      we_d    = fifo_we[rd_ptr_q];
      adr_d   = fifo_adr[rd_ptr_q];
      dat_d   = fifo_dat[rd_ptr_q];
      sel_d   = fifo_sel[rd_ptr_q];
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      retry_d = '0;
      state_d = StCycle;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);
  logic [WaitW-1:0] wait_q, wait_d;

  assign tmo = (state_q == StCycle) && (wait_q == WaitW'(TIMEOUT_CYC - 1));

  always_comb begin
    wait_d = wait_q;
    if (state_d == StCycle && state_q != StCycle) wait_d = '0;
    else if (state_q == StCycle)                  wait_d = wait_q + WaitW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      status_q  <= StsOk;
      retry_q   <= '0;
      bo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      status_q  <= status_d;
      retry_q   <= retry_d;
      bo_q      <= bo_d;
    end
  end

  assign wb.CYC_O    = cyc_q;
  assign wb.STB_O    = stb_q;
  assign wb.WE_O     = we_q;
  assign wb.LOCK_O   = 1'b0;
  assign wb.ADR_O    = adr_q;
  assign wb.DAT_O    = dat_q;
  assign wb.SEL_O    = sel_q;
  assign rsp_valid   = (state_q == StResp);
  assign rsp_dat     = rsp_dat_q;
  assign rsp_status  = status_q;
endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine; the timeout scenario builds only with WB_MASTER_TIMEOUT_EN.
module tb_wb_master_engine;
  localparam int KAck = 0, KErr = 1, KRty = 2, KErrAck = 3;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [63:0] cmd_adr, cmd_dat;
  logic [7:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_dat;
  logic [1:0]  rsp_status;
  int          errors = 0;
  int          checks = 0;

  wb_master_engine_if #(.DATA_W(64), .ADR_W(64)) wb ();

  wb_master_engine #(
    .DATA_W(64), .ADR_W(64), .CMD_DEPTH(4), .MAX_RETRY(3), .BACKOFF(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .wb(wb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                      input logic [7:0] sel);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Slave side of one STB phase: terminate after ws wait states; high=-1 if no phase starts.
  task automatic serve(input int ws, input int kind, input logic [63:0] rdat,
                       output int gap, output int high, output logic we_s,
                       output logic [63:0] adr_s, output logic [63:0] dat_s);
    gap = 0; high = 0; we_s = 1'b0; adr_s = '0; dat_s = '0;
    while (!wb.CYC_O && gap < 50) begin
      tick();
      gap++;
    end
    if (!wb.CYC_O) begin
      high = -1;
      return;
    end
    we_s = wb.WE_O; adr_s = wb.ADR_O; dat_s = wb.DAT_O;
    while (wb.CYC_O && high < 50) begin
      high++;
      if (high == ws + 1) begin
        wb.DAT_I = rdat;
        wb.ACK_I = (kind == KAck || kind == KErrAck);
        wb.ERR_I = (kind == KErr || kind == KErrAck);
        wb.RTY_I = (kind == KRty);
      end
      tick();
      wb.ACK_I = 1'b0; wb.ERR_I = 1'b0; wb.RTY_I = 1'b0; wb.DAT_I = '0;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (wb.CYC_O !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b want 0", wb.CYC_O); end
    checks++; if (wb.STB_O !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", wb.STB_O); end
    checks++; if (wb.WE_O !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", wb.WE_O); end
    checks++; if (wb.ADR_O !== 64'h0) begin errors++; $display("FAIL reset_adr got %h want 0", wb.ADR_O); end
    checks++; if (wb.LOCK_O !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", wb.LOCK_O); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_dat !== 64'h0) begin errors++; $display("FAIL reset_rsp_dat got %h want 0", rsp_dat); end
    checks++; if (rsp_status !== 2'b00) begin errors++; $display("FAIL reset_status got %b want 00", rsp_status); end
    rst_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    int gap, high; logic we_s; logic [63:0] adr_s, dat_s;
    push(1'b1, 64'h100, 64'hDEADBEEF, 8'hFF);
    checks++; if (wb.CYC_O !== 1'b0) begin errors++; $display("FAIL wr_cyc_at_accept got %b want 0", wb.CYC_O); end
    checks++; if (wb.SEL_O !== 8'h00) begin errors++; $display("FAIL wr_sel_before got %h want 00", wb.SEL_O); end
    serve(2, KAck, 64'h0, gap, high, we_s, adr_s, dat_s);
    checks++; if (gap !== 1) begin errors++; $display("FAIL wr_latency got %0d want 1", gap); end
    checks++; if (high !== 3) begin errors++; $display("FAIL wr_cyc_len got %0d want 3", high); end
    checks++; if (we_s !== 1'b1) begin errors++; $display("FAIL wr_we got %b want 1", we_s); end
    checks++; if (adr_s !== 64'h100) begin errors++; $display("FAIL wr_adr got %h want 100", adr_s); end
    checks++; if (dat_s !== 64'hDEADBEEF) begin errors++; $display("FAIL wr_dat got %h want deadbeef", dat_s); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_status !== 2'b00) begin errors++; $display("FAIL wr_status got %b want 00", rsp_status); end
    take_rsp();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_drop got %b want 0", rsp_valid); end
  endtask

  task automatic test_read();
    int gap, high; logic we_s; logic [63:0] adr_s, dat_s;
    push(1'b0, 64'h200, 64'h0, 8'hFF);
    serve(0, KAck, 64'h1234, gap, high, we_s, adr_s, dat_s);
    checks++; if (high !== 1) begin errors++; $display("FAIL rd_cyc_len got %0d want 1", high); end
    checks++; if (we_s !== 1'b0) begin errors++; $display("FAIL rd_we got %b want 0", we_s); end
    checks++; if (adr_s !== 64'h200) begin errors++; $display("FAIL rd_adr got %h want 200", adr_s); end
    checks++; if (rsp_dat !== 64'h1234) begin errors++; $display("FAIL rd_dat got %h want 1234", rsp_dat); end
    checks++; if (rsp_status !== 2'b00) begin errors++; $display("FAIL rd_status got %b want 00", rsp_status); end
    take_rsp();
  endtask

  task automatic test_retry();
    int gap, high; logic we_s; logic [63:0] adr_s, dat_s;
    push(1'b1, 64'h300, 64'h55, 8'h0F);
    serve(0, KRty, 64'h0, gap, high, we_s, adr_s, dat_s);
    serve(0, KRty, 64'h0, gap, high, we_s, adr_s, dat_s);
    checks++; if (gap !== 2) begin errors++; $display("FAIL rty_gap1 got %0d want 2", gap); end
    checks++; if (adr_s !== 64'h300) begin errors++; $display("FAIL rty_reissue_adr got %h want 300", adr_s); end
    serve(0, KAck, 64'h0, gap, high, we_s, adr_s, dat_s);
    checks++; if (gap !== 2) begin errors++; $display("FAIL rty_gap2 got %0d want 2", gap); end
    checks++; if (rsp_status !== 2'b00) begin errors++; $display("FAIL rty_ok_status got %b want 00", rsp_status); end
    take_rsp();
    push(1'b1, 64'h310, 64'h66, 8'hF0);
    for (int i = 0; i < 3; i++) serve(0, KRty, 64'h0, gap, high, we_s, adr_s, dat_s);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rty_early_rsp got %b want 0", rsp_valid); end
    serve(0, KRty, 64'h0, gap, high, we_s, adr_s, dat_s);
    checks++; if (high !== 1) begin errors++; $display("FAIL rty_phase4 got %0d want 1", high); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rty_exh_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_status !== 2'b10) begin errors++; $display("FAIL rty_exh_status got %b want 10", rsp_status); end
    take_rsp();
    repeat (3) tick();
    checks++; if (wb.CYC_O !== 1'b0) begin errors++; $display("FAIL rty_no_5th got %b want 0", wb.CYC_O); end
  endtask

  task automatic test_err_ack();
    int gap, high; logic we_s; logic [63:0] adr_s, dat_s;
    push(1'b0, 64'h400, 64'h0, 8'hFF);
    serve(1, KErrAck, 64'hAAAA, gap, high, we_s, adr_s, dat_s);
    checks++; if (high !== 2) begin errors++; $display("FAIL err_cyc_len got %0d want 2", high); end
    checks++; if (rsp_status !== 2'b01) begin errors++; $display("FAIL err_status got %b want 01", rsp_status); end
    checks++; if (rsp_dat !== 64'h0) begin errors++; $display("FAIL err_dat got %h want 0", rsp_dat); end
    take_rsp();
  endtask

  task automatic test_back_to_back();
    int gap, high; logic we_s; logic [63:0] adr_s, dat_s;
    logic rdy [6];
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 64'h1000 + 64'(i); cmd_dat = '0; cmd_sel = 8'hFF;
      rdy[i] = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rdy[i] !== (i < 5)) begin
        errors++; $display("FAIL q_ready[%0d] got %b want %b", i, rdy[i], (i < 5));
      end
    end
    for (int k = 0; k < 5; k++) begin
      serve(0, KAck, 64'h5000 + 64'(k), gap, high, we_s, adr_s, dat_s);
      checks++;
      if (adr_s !== 64'h1000 + 64'(k)) begin
        errors++; $display("FAIL q_adr[%0d] got %h want %h", k, adr_s, 64'h1000 + 64'(k));
      end
      checks++;
      if (rsp_dat !== 64'h5000 + 64'(k)) begin
        errors++; $display("FAIL q_dat[%0d] got %h want %h", k, rsp_dat, 64'h5000 + 64'(k));
      end
      take_rsp();
    end
    tick();
    checks++; if (wb.CYC_O !== 1'b0) begin errors++; $display("FAIL q_drained got %b want 0", wb.CYC_O); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL q_ready_end got %b want 1", cmd_ready); end
  endtask

  task automatic test_reset_mid();
    int t; logic seen;
    push(1'b1, 64'h600, 64'h77, 8'hFF);
    t = 0;
    while (!wb.CYC_O && t < 10) begin tick(); t++; end
    checks++; if (wb.CYC_O !== 1'b1) begin errors++; $display("FAIL mid_cyc_up got %b want 1", wb.CYC_O); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wb.CYC_O !== 1'b0) begin errors++; $display("FAIL mid_cyc_drop got %b want 0", wb.CYC_O); end
    checks++; if (wb.STB_O !== 1'b0) begin errors++; $display("FAIL mid_stb_drop got %b want 0", wb.STB_O); end
    #10 rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (rsp_valid || wb.CYC_O) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got %b want 0", seen); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", cmd_ready); end
  endtask

`ifdef WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int gap, high; logic we_s; logic [63:0] adr_s, dat_s;
    push(1'b0, 64'h700, 64'h0, 8'hFF);
    serve(100, KAck, 64'h0, gap, high, we_s, adr_s, dat_s);
    checks++; if (high !== 16) begin errors++; $display("FAIL tmo_len got %0d want 16", high); end
    checks++; if (rsp_status !== 2'b11) begin errors++; $display("FAIL tmo_status got %b want 11", rsp_status); end
    take_rsp();
  endtask
`endif

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;
    wb.DAT_I = '0; wb.ACK_I = 1'b0; wb.ERR_I = 1'b0; wb.RTY_I = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_retry();
    test_err_ack();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
